// File: rtl/mem_pkg.sv
// Shared types and geometry helpers for the banked RAM family.
// The state enum is common to every RAM variant in the memory tree.
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    function automatic int bank_count(input int bank_bits);
        return 1 << bank_bits;
    endfunction

    function automatic int bank_depth(input int aw, input int bank_bits);
        return 1 << (aw - bank_bits);
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One RAM bank: synchronous write, asynchronous read.
// The array is deliberately left without a reset.
module ram_bank
    import mem_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int AW        = 9,
    parameter int BANK_BITS = 3
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-BANK_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [AW-BANK_BITS-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);

    logic [WIDTH-1:0] mem [bank_depth(AW, BANK_BITS)];

    // NOTE: storage arrays get no reset term; the owner's clear sweep zeroes them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/banked_ram_clr.sv
// Parametrised banked RAM with a hardware clear sweep after reset or on clr.
// busy is high while the sweep owns the write port.
module banked_ram_clr
    import mem_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int AW        = 9,
    parameter int BANK_BITS = 3,
    parameter int REG_OUT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [AW-1:0]    address,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam int IAW = AW - BANK_BITS;
    localparam int NB  = bank_count(BANK_BITS);
    localparam int BSW = (BANK_BITS > 0) ? BANK_BITS : 1;

    ram_state_t       state, state_nxt;
    logic [AW-1:0]    cnt, cnt_nxt;
    logic             wen;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [BSW-1:0]   wbank, rbank;
    logic [NB-1:0]    bank_we;
    logic [WIDTH-1:0] bank_rd [NB];
    logic [WIDTH-1:0] rd_sel;
    logic [WIDTH-1:0] rd_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wen       = 1'b0;
        waddr     = address;
        wdata     = in;
        unique case (state)
            CLEAR: begin
                wen     = 1'b1;
                waddr   = cnt;
                wdata   = '0;
                cnt_nxt = cnt + AW'(1);
                if (cnt == '1) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else begin
                    wen = load;
                end
            end
        endcase
    end

    // A zero-bit bank field collapses to a single bank.
    if (BANK_BITS > 0) begin : g_bank_field
        assign wbank = waddr[AW-1 -: BANK_BITS];
        assign rbank = address[AW-1 -: BANK_BITS];
    end else begin : g_single_bank
        assign wbank = '0;
        assign rbank = '0;
    end

    always_comb begin
        bank_we = '0;
        for (int b = 0; b < NB; b++) begin
            bank_we[b] = wen && (wbank == BSW'(b));
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_bank
        ram_bank #(
            .WIDTH     (WIDTH),
            .AW        (AW),
            .BANK_BITS (BANK_BITS)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[g]),
            .waddr (waddr[IAW-1:0]),
            .wdata (wdata),
            .raddr (address[IAW-1:0]),
            .rdata (bank_rd[g])
        );
    end

    always_comb begin
        rd_sel = '0;
        for (int b = 0; b < NB; b++) begin
            if (rbank == BSW'(b)) begin
                rd_sel = bank_rd[b];
            end
        end
    end

    // Registered read samples before the bank write lands, giving read-before-write.
    if (REG_OUT != 0) begin : g_reg_out
        logic [WIDTH-1:0] out_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= '0;
            end else if (state == CLEAR) begin
                out_q <= '0;
            end else begin
                out_q <= rd_sel;
            end
        end

        assign rd_value = out_q;
    end else begin : g_comb_out
        assign rd_value = rd_sel;
    end

    assign out  = (state == READY) ? rd_value : '0;
    assign busy = (state == CLEAR);

endmodule

// File: tb/tb_banked_ram_clr.sv
// Self-checking bench: combinational and registered 16x512 RAMs share stimulus,
// a small 8x16 single-bank instance is exercised separately.
module tb_banked_ram_clr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        load;
    logic [8:0]  address;
    logic        clr;
    logic [15:0] c_out, r_out;
    logic        c_busy, r_busy;

    logic        s_rst_n;
    logic [7:0]  s_din;
    logic        s_load;
    logic [3:0]  s_address;
    logic        s_clr;
    logic [7:0]  s_out;
    logic        s_busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model   [512];
    logic [7:0]  s_model [16];
    logic [15:0] q_c [$];
    logic [15:0] q_r [$];
    logic [7:0]  q_s [$];

    always #5 clk = ~clk;

    banked_ram_clr #(.WIDTH(16), .AW(9), .BANK_BITS(3), .REG_OUT(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in(din), .load(load), .address(address),
        .clr(clr), .out(c_out), .busy(c_busy)
    );

    banked_ram_clr #(.WIDTH(16), .AW(9), .BANK_BITS(3), .REG_OUT(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in(din), .load(load), .address(address),
        .clr(clr), .out(r_out), .busy(r_busy)
    );

    banked_ram_clr #(.WIDTH(8), .AW(4), .BANK_BITS(0), .REG_OUT(0)) dut_s (
        .clk(clk), .rst_n(s_rst_n), .in(s_din), .load(s_load), .address(s_address),
        .clr(s_clr), .out(s_out), .busy(s_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered at posedge+1; returns at posedge+1 after one edge.
    task automatic rw(input logic ld, input logic [8:0] a, input logic [15:0] d);
        logic [15:0] e;
        load    = ld;
        address = a;
        din     = d;
        clr     = 1'b0;
        q_c.push_back(model[a]);
        q_r.push_back(model[a]);
        #4;
        e = q_c.pop_front();
        check($sformatf("c_rd@%0d", a), 32'(c_out), 32'(e));
        @(posedge clk);
        if (ld) model[a] = d;
        #1;
        e = q_r.pop_front();
        check($sformatf("r_rd@%0d", a), 32'(r_out), 32'(e));
        load = 1'b0;
    endtask

    task automatic s_rw(input logic ld, input logic [3:0] a, input logic [7:0] d);
        logic [7:0] e;
        s_load    = ld;
        s_address = a;
        s_din     = d;
        s_clr     = 1'b0;
        q_s.push_back(s_model[a]);
        #4;
        e = q_s.pop_front();
        check($sformatf("s_rd@%0d", a), 32'(s_out), 32'(e));
        @(posedge clk);
        if (ld) s_model[a] = d;
        #1;
        s_load = 1'b0;
    endtask

    // Counts edges until busy drops; inputs are released as soon as it does.
    task automatic sweep_main(input string tag, input int expect_len);
        int   n   = 0;
        logic bad = 1'b0;
        while (c_busy && n < 4000) begin
            if (c_out != 16'h0 || r_out != 16'h0 || r_busy !== c_busy) bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        load = 1'b0;
        clr  = 1'b0;
        check({tag, "_len"}, 32'(n), 32'(expect_len));
        check({tag, "_r_busy"}, 32'(r_busy), 32'd0);
        check({tag, "_out0"}, 32'(bad), 32'd0);
        foreach (model[i]) model[i] = 16'h0;
    endtask

    task automatic sweep_s(input string tag, input int expect_len);
        int   n   = 0;
        logic bad = 1'b0;
        while (s_busy && n < 200) begin
            if (s_out != 8'h0) bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        s_load = 1'b0;
        s_clr  = 1'b0;
        check({tag, "_len"}, 32'(n), 32'(expect_len));
        check({tag, "_out0"}, 32'(bad), 32'd0);
        foreach (s_model[i]) s_model[i] = 8'h0;
    endtask

    initial begin
        rst_n = 1'b0; din = '0; load = 1'b0; address = '0; clr = 1'b0;
        s_rst_n = 1'b0; s_din = '0; s_load = 1'b0; s_address = '0; s_clr = 1'b0;
        foreach (model[i]) model[i] = 16'h0;
        foreach (s_model[i]) s_model[i] = 8'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_c_busy", 32'(c_busy), 32'd1);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_r_busy", 32'(r_busy), 32'd1);
        check("rst_r_out", 32'(r_out), 32'd0);

        // Reset sweep with load and clr held: both must be ignored while busy.
        rst_n   = 1'b1;
        load    = 1'b1;
        address = 9'd0;
        din     = 16'h9999;
        clr     = 1'b1;
        sweep_main("rst_sweep", 512);
        foreach (model[i]) model[i] = 16'h0;
        rw(1'b0, 9'd0, 16'h0);
        rw(1'b0, 9'd63, 16'h0);
        rw(1'b0, 9'd64, 16'h0);
        rw(1'b0, 9'd511, 16'h0);

        // Bank boundaries.
        rw(1'b1, 9'd63, 16'h1234);
        rw(1'b1, 9'd64, 16'hBEEF);
        rw(1'b1, 9'd511, 16'hFFFF);
        rw(1'b0, 9'd63, 16'h0);
        rw(1'b0, 9'd64, 16'h0);
        rw(1'b0, 9'd511, 16'h0);
        rw(1'b0, 9'd62, 16'h0);
        rw(1'b0, 9'd65, 16'h0);

        // Back-to-back writes to one address: registered port returns the old word.
        rw(1'b1, 9'd5, 16'hAAAA);
        rw(1'b1, 9'd5, 16'h5555);
        rw(1'b0, 9'd5, 16'h0);
        rw(1'b0, 9'd5, 16'h0);

        // clr and load together: clr wins, nothing is written.
        clr = 1'b1; load = 1'b1; din = 16'h7777; address = 9'd10;
        @(posedge clk);
        #1;
        load = 1'b0; clr = 1'b0;
        check("clr_busy", 32'(c_busy), 32'd1);
        sweep_main("clr_sweep", 512);
        rw(1'b0, 9'd10, 16'h0);
        rw(1'b0, 9'd63, 16'h0);
        rw(1'b0, 9'd5, 16'h0);

        // Reset mid-sweep.
        rw(1'b1, 9'd300, 16'hCAFE);
        rw(1'b0, 9'd300, 16'h0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (200) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_c_busy", 32'(c_busy), 32'd1);
        check("midrst_c_out", 32'(c_out), 32'd0);
        check("midrst_r_busy", 32'(r_busy), 32'd1);
        check("midrst_r_out", 32'(r_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep_main("midrst_sweep", 512);
        rw(1'b0, 9'd300, 16'h0);

        // Small single-bank instance.
        s_rst_n = 1'b1;
        sweep_s("s_rst_sweep", 16);
        s_rw(1'b1, 4'd0, 8'hA5);
        s_rw(1'b1, 4'd15, 8'h3C);
        s_rw(1'b1, 4'd7, 8'hFF);
        s_rw(1'b0, 4'd0, 8'h0);
        s_rw(1'b0, 4'd15, 8'h0);
        s_rw(1'b0, 4'd7, 8'h0);
        s_rw(1'b0, 4'd1, 8'h0);
        s_clr = 1'b1;
        @(posedge clk);
        #1;
        s_clr = 1'b0;
        sweep_s("s_clr_sweep", 16);
        s_rw(1'b0, 4'd15, 8'h0);
        s_rw(1'b0, 4'd0, 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/banked_ram_clr.md
# banked_ram_clr

Parametrised banked RAM, successor to the fixed 16-bit × 512 hierarchical RAM used in the memory tree. Width, depth, bank count and read latency are all configurable. It adds a hardware clear sweep that zeroes every word after reset or on request, and a `busy` flag that gates access during the sweep. It sits wherever the fixed-size RAM blocks sit today, including data memory and screen/scratch memory.

## Interface
Parameters:
- `WIDTH`, 16: data word width in bits, ≥1.
- `AW`, 9: address width; total depth is `2**AW` words.
- `BANK_BITS`, 3: bank-select bits, 0 ≤ `BANK_BITS` < `AW`; there are `2**BANK_BITS` banks of `2**(AW-BANK_BITS)` words.
- `REG_OUT`, 0: read mode. 0 is a combinational read; 1 is a registered read with one-cycle latency.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in`, in, `WIDTH`: write data.
- `load`, in, 1: write enable.
- `address`, in, `AW`: word address. The bank is `address[AW-1 -: BANK_BITS]`; the in-bank word is `address[AW-BANK_BITS-1:0]`.
- `clr`, in, 1: synchronous clear request, sampled only in READY.
- `out`, out, `WIDTH`: read data.
- `busy`, out, 1: high while the clear sweep is running.

## Operation
- **FSM states:** CLEAR and READY.
- **Reset (`rst_n`=0):** state is CLEAR, sweep counter `cnt`=0, `busy`=1, `out`=0. Array contents are not reset directly.
- **CLEAR:**
  - Each rising edge writes 0 to word `cnt` and increments `cnt`.
  - The edge that writes word `2**AW-1` moves the FSM to READY and clears `busy`.
  - `load`, `clr` and `address` are ignored; `out` is forced to 0.
- **READY, write:** when `load`=1, the rising edge writes `in` to `mem[address]`. Exactly one bank's write enable is high (one-hot decode of the bank field).
- **READY, read:**
  - The in-bank address goes to all banks; the bank field muxes the selected bank's data to `out`.
  - With `REG_OUT`=0: `out` = `mem[address]` combinationally. A write becomes visible after its edge.
  - With `REG_OUT`=1: `out` registers `mem[address]` each edge with read-before-write semantics, so the old data is returned when the same address is written on that edge.
- **Clear request:** `clr`=1 in READY makes the next edge enter CLEAR with `cnt`=0. No write happens on that edge, and `load` on the same cycle is dropped (`clr` wins).
- **Reset mid-sweep:** the sweep aborts immediately and restarts from word 0 after release.
- **Counter:** `cnt` is `AW` bits wide; its wrap from `2**AW-1` to 0 coincides with the transition to READY.

## Timing
- **Sweep length:** `busy` stays high for exactly `2**AW` rising edges after `rst_n` rises, or after the edge that samples `clr`. With default parameters this is 512 cycles.
- **First access:** the first edge at which `load` is honoured is the first edge with `busy`=0 already sampled low.
- **Read latency:** 0 cycles with `REG_OUT`=0, 1 cycle with `REG_OUT`=1.
- **Registered output during the sweep:** with `REG_OUT`=1, `out` is 0 on the edge that leaves CLEAR and reflects `mem[address]` from the next edge on.
- **Output reset values:** `out`=0 and `busy`=1.

## Structure
- **Shared package `mem_pkg`:**
  - state enum `ram_state_t` {CLEAR, READY};
  - helper functions for bank count and bank depth from `AW`/`BANK_BITS`.
- **Sub-module `ram_bank`:** one `WIDTH` × `2**(AW-BANK_BITS)` bank with synchronous write and asynchronous read. The top level instantiates `2**BANK_BITS` of them in a generate loop and contains the sweep FSM, the decode and the output mux/register.
- **Write port:** during CLEAR, the bank write port is driven by `cnt` and data 0.

## Test plan
- **Reset sweep:** release `rst_n` -> `busy`=1 for exactly 512 cycles and `out`=0 throughout; after the sweep, reads of addresses 0, 63, 64 and 511 all return 0.
- **Bank boundaries:** write 0x1234 @63, 0xBEEF @64 and 0xFFFF @511, then read each back -> exact values, and addresses 62 and 65 remain 0. This checks the bank decode at the bank edges.
- **Registered read, `REG_OUT`=1:**
  - Write 0xAAAA @5.
  - On the next cycle, write 0x5555 @5 -> `out` shows 0xAAAA one cycle later.
  - Idle on @5 -> `out` shows 0x5555.
- **Clear versus load:** with 0x1234 stored @63, assert `clr` and `load` (`in`=0x7777, @10) together -> `busy` for 512 cycles; afterwards both @10 and @63 read 0.
- **Ignored writes during sweep:** assert `load` @0 with 0x9999 while `busy` -> after the sweep, @0 reads 0.
- **Reset mid-sweep:** pull `rst_n` low at sweep cycle 200 -> `busy`=1 and `out`=0 immediately; after release, `busy` stays high for a full 512 cycles.
- **Alternate parameters:** repeat the write/read and sweep checks with `WIDTH`=8, `AW`=4, `BANK_BITS`=0 -> a 16-cycle sweep and correct 8-bit data.
